// File: rtl/fir_sample_delay_line.sv
// -----------------------------------------------------------------------------
// fir_sample_delay_line
//
// Circular sample history for a time-multiplexed TAPS-tap FIR MAC stage.
// Input samples arrive on a low-rate strobe and are held in a one-deep pending
// register. They enter the history only at a frame boundary, so each
// TAPS-cycle frame sees a coherent window. Every clock in RUN the block
// presents one delayed sample x[n-k] together with its tap index k, so the MAC
// can pair it with coefficient h[k].
//
// After reset the block spends exactly TAPS cycles in CLEAR, zeroing the
// history one entry per cycle. It then enters RUN and stays there until the
// next reset.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   din        new input sample (two's complement, WIDTH bits)
//   din_valid  one-cycle strobe qualifying din
//   x_out      delayed sample x[n-tap_out] (registered)
//   tap_out    tap index k matching x_out (registered)
//   x_valid    x_out/tap_out are valid (registered)
//   frame_end  high with the last tap of a frame (registered)
//   ready      high while in RUN (registered)
//   overrun    sticky: a pending sample was overwritten before commit
// -----------------------------------------------------------------------------
module fir_sample_delay_line #(
    parameter int TAPS      = 64,
    parameter int ADDR_BITS = 6,
    parameter int WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    output logic [WIDTH-1:0]     x_out,
    output logic [ADDR_BITS-1:0] tap_out,
    output logic                 x_valid,
    output logic                 frame_end,
    output logic                 ready,
    output logic                 overrun
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Pointer arithmetic relies on the natural ADDR_BITS wrap, so TAPS must
    // equal 2**ADDR_BITS.
    localparam logic [ADDR_BITS-1:0] LAST_TAP = ADDR_BITS'(TAPS - 1);
    localparam logic [ADDR_BITS-1:0] ONE_ADDR = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ZERO_ADDR = ADDR_BITS'(0);
    localparam logic [WIDTH-1:0]     ZERO_SAMPLE = WIDTH'(0);

    state_t                 state_r;
    logic [ADDR_BITS-1:0]   k_r;
    logic [ADDR_BITS-1:0]   base_r;
    logic [WIDTH-1:0]       pend_r;
    logic                   pend_valid_r;
    logic [WIDTH-1:0]       mem_r [TAPS];

    logic [WIDTH-1:0]       x_out_r;
    logic [ADDR_BITS-1:0]   tap_out_r;
    logic                   x_valid_r;
    logic                   frame_end_r;
    logic                   ready_r;
    logic                   overrun_r;

    logic                   last_tap_s;
    logic                   commit_s;
    logic                   wr_en_s;
    logic [ADDR_BITS-1:0]   rd_addr_s;
    logic [ADDR_BITS-1:0]   wr_addr_s;
    logic [WIDTH-1:0]       wr_data_s;

    // Read/write address and commit decode for the current cycle.
    always_comb begin
        last_tap_s = (k_r == LAST_TAP);
        commit_s   = (state_r == ST_RUN) && last_tap_s && pend_valid_r;
        rd_addr_s  = base_r + k_r;
        wr_en_s    = 1'b0;
        wr_addr_s  = ZERO_ADDR;
        wr_data_s  = ZERO_SAMPLE;
        case (state_r)
            ST_CLEAR: begin
                // Sweep the whole array with zeros, one entry per cycle.
                wr_en_s   = 1'b1;
                wr_addr_s = k_r;
                wr_data_s = ZERO_SAMPLE;
            end
            ST_RUN: begin
                // On the commit cycle the write address (base-1) equals the
                // read address (base+TAPS-1). The registered read therefore
                // still returns the oldest sample for the closing frame.
                wr_en_s   = commit_s;
                wr_addr_s = base_r - ONE_ADDR;
                wr_data_s = pend_r;
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_addr_s = ZERO_ADDR;
                wr_data_s = ZERO_SAMPLE;
            end
        endcase
    end

    // History storage; cleared by the CLEAR sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Control FSM, pointers, pending-sample capture and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_CLEAR;
            k_r          <= ZERO_ADDR;
            base_r       <= ZERO_ADDR;
            pend_r       <= ZERO_SAMPLE;
            pend_valid_r <= 1'b0;
            x_out_r      <= ZERO_SAMPLE;
            tap_out_r    <= ZERO_ADDR;
            x_valid_r    <= 1'b0;
            frame_end_r  <= 1'b0;
            ready_r      <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            // k wraps naturally from TAPS-1 to 0 in both states.
            k_r <= k_r + ONE_ADDR;
            case (state_r)
                ST_CLEAR: begin
                    x_valid_r   <= 1'b0;
                    frame_end_r <= 1'b0;
                    if (last_tap_s) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_CLEAR;
                        ready_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    x_out_r     <= mem_r[rd_addr_s];
                    tap_out_r   <= k_r;
                    x_valid_r   <= 1'b1;
                    frame_end_r <= last_tap_s;
                    ready_r     <= 1'b1;
                    // Newest sample always sits at base, so moving base down
                    // by one shifts every older sample one tap further out.
                    if (commit_s) begin
                        base_r <= base_r - ONE_ADDR;
                    end else begin
                        base_r <= base_r;
                    end
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    k_r         <= ZERO_ADDR;
                    x_valid_r   <= 1'b0;
                    frame_end_r <= 1'b0;
                    ready_r     <= 1'b0;
                end
            endcase

            // A strobe in the commit cycle refills pend as the old value is
            // committed, so it is not an overrun.
            if (din_valid) begin
                pend_r       <= din;
                pend_valid_r <= 1'b1;
                if (pend_valid_r && !commit_s) begin
                    overrun_r <= 1'b1;
                end else begin
                    overrun_r <= overrun_r;
                end
            end else if (commit_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
        end
    end

    assign x_out     = x_out_r;
    assign tap_out   = tap_out_r;
    assign x_valid   = x_valid_r;
    assign frame_end = frame_end_r;
    assign ready     = ready_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_fir_sample_delay_line.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fir_sample_delay_line.
// A shift-register history model produces the expected frames. Each scenario
// pushes them onto a scoreboard queue, and they are popped as the DUT emits
// each frame.
// -----------------------------------------------------------------------------
module tb_fir_sample_delay_line;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        din_valid = 1'b0;
    logic [15:0] x_out;
    logic [5:0]  tap_out;
    logic        x_valid;
    logic        frame_end;
    logic        ready;
    logic        overrun;

    fir_sample_delay_line #(.TAPS(64), .ADDR_BITS(6), .WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .x_out     (x_out),
        .tap_out   (tap_out),
        .x_valid   (x_valid),
        .frame_end (frame_end),
        .ready     (ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  tap;
        logic [15:0] x;
        logic        fe;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] hist [64];
    logic [15:0] got_x [64];
    logic [5:0]  got_tap [64];
    logic        got_v [64];
    logic        got_fe [64];
    logic        got_ov [64];
    logic        se [64];
    logic [15:0] sv [64];
    int          n_pass = 0;
    int          n_total = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) hist[i] = 16'h0000;
    endfunction

    // Newest sample goes to tap 0; everything else moves one tap older.
    function automatic void model_commit(input logic [15:0] v);
        for (int k = 63; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = v;
    endfunction

    function automatic void push_frame();
        for (int t = 0; t < 64; t++) begin
            exp_t e;
            e.tap = 6'(t);
            e.x   = hist[t];
            e.fe  = (t == 63);
            exp_q.push_back(e);
        end
    endfunction

    function automatic void clear_strobes();
        for (int i = 0; i < 64; i++) begin
            se[i] = 1'b0;
            sv[i] = 16'h0000;
        end
    endfunction

    // Record one frame. din_valid is driven during the cycle that shows tap i
    // when se[i] is set, so se[62] lands on the commit edge.
    task automatic capture_frame();
        for (int i = 0; i < 64; i++) begin
            step();
            got_x[i]   = x_out;
            got_tap[i] = tap_out;
            got_v[i]   = x_valid;
            got_fe[i]  = frame_end;
            got_ov[i]  = overrun;
            din_valid  = se[i];
            din        = sv[i];
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        exp_t e;
        reset = 1'b1;
        step();
        n_total++;
        if ({x_out, tap_out, x_valid, frame_end, ready, overrun} !== 26'h0)
            $display("FAIL reset_outputs: got x=%h tap=%0d v=%b fe=%b rdy=%b ov=%b, want all 0",
                     x_out, tap_out, x_valid, frame_end, ready, overrun);
        else n_pass++;
        step();
        reset = 1'b0;
        wait_ready(cyc);
        n_total++;
        if (cyc !== 64) $display("FAIL clear_length: got %0d cycles, want 64", cyc);
        else n_pass++;
        n_total++;
        if (x_valid !== 1'b0) $display("FAIL valid_with_ready: got x_valid=%b, want 0", x_valid);
        else n_pass++;
        model_clear();
        push_frame();
        capture_frame();
        for (int i = 0; i < 64; i++) begin
            e = exp_q.pop_front();
            n_total++;
            if ({got_v[i], got_tap[i], got_x[i], got_fe[i]} !== {1'b1, e.tap, e.x, e.fe})
                $display("FAIL idle_frame[%0d]: got v=%b tap=%0d x=%h fe=%b, want v=1 tap=%0d x=%h fe=%b",
                         i, got_v[i], got_tap[i], got_x[i], got_fe[i], e.tap, e.x, e.fe);
            else n_pass++;
        end
    endtask

    task automatic test_single_sample();
        int cyc;
        exp_t e;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        din = 16'h1234;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        wait_ready(cyc);
        n_total++;
        if (ready !== 1'b1) $display("FAIL single_ready: got %b, want 1", ready);
        else n_pass++;
        model_clear();
        push_frame();
        model_commit(16'h1234);
        push_frame();
        push_frame();
        for (int f = 0; f < 3; f++) begin
            clear_strobes();
            capture_frame();
            for (int i = 0; i < 64; i++) begin
                e = exp_q.pop_front();
                n_total++;
                if ({got_v[i], got_tap[i], got_x[i], got_fe[i]} !== {1'b1, e.tap, e.x, e.fe})
                    $display("FAIL single_frame%0d[%0d]: got v=%b tap=%0d x=%h fe=%b, want v=1 tap=%0d x=%h fe=%b",
                             f, i, got_v[i], got_tap[i], got_x[i], got_fe[i], e.tap, e.x, e.fe);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sample_stream();
        int cyc;
        exp_t e;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        wait_ready(cyc);
        model_clear();
        for (int f = 0; f <= 65; f++) begin
            clear_strobes();
            if (f < 65) begin
                se[10] = 1'b1;
                sv[10] = 16'(f + 1);
            end
            push_frame();
            capture_frame();
            for (int i = 0; i < 64; i++) begin
                e = exp_q.pop_front();
                n_total++;
                if ({got_v[i], got_tap[i], got_x[i], got_fe[i]} !== {1'b1, e.tap, e.x, e.fe})
                    $display("FAIL stream_frame%0d[%0d]: got v=%b tap=%0d x=%h fe=%b, want v=1 tap=%0d x=%h fe=%b",
                             f, i, got_v[i], got_tap[i], got_x[i], got_fe[i], e.tap, e.x, e.fe);
                else n_pass++;
            end
            if (f < 65) model_commit(16'(f + 1));
        end
        n_total++;
        if (got_x[0] !== 16'h0041) $display("FAIL stream_tap0: got %h, want 0041", got_x[0]);
        else n_pass++;
        n_total++;
        if (got_x[63] !== 16'h0002) $display("FAIL stream_tap63: got %h, want 0002", got_x[63]);
        else n_pass++;
    endtask

    task automatic test_coincident();
        exp_t e;
        for (int f = 0; f < 3; f++) begin
            clear_strobes();
            if (f == 0) begin
                se[30] = 1'b1; sv[30] = 16'h0AAA;
                se[62] = 1'b1; sv[62] = 16'h0BBB;
            end
            push_frame();
            capture_frame();
            for (int i = 0; i < 64; i++) begin
                e = exp_q.pop_front();
                n_total++;
                if ({got_v[i], got_tap[i], got_x[i], got_fe[i], got_ov[i]} !== {1'b1, e.tap, e.x, e.fe, 1'b0})
                    $display("FAIL coinc_frame%0d[%0d]: got v=%b tap=%0d x=%h fe=%b ov=%b, want v=1 tap=%0d x=%h fe=%b ov=0",
                             f, i, got_v[i], got_tap[i], got_x[i], got_fe[i], got_ov[i], e.tap, e.x, e.fe);
                else n_pass++;
            end
            if (f == 0) model_commit(16'h0AAA);
            if (f == 1) model_commit(16'h0BBB);
        end
        n_total++;
        if ({got_x[0], got_x[1]} !== {16'h0BBB, 16'h0AAA})
            $display("FAIL coinc_taps: got tap0=%h tap1=%h, want 0bbb 0aaa", got_x[0], got_x[1]);
        else n_pass++;
    endtask

    task automatic test_overrun();
        exp_t e;
        for (int f = 0; f < 3; f++) begin
            clear_strobes();
            if (f == 0) begin
                se[5]  = 1'b1; sv[5]  = 16'h1111;
                se[20] = 1'b1; sv[20] = 16'h2222;
            end
            push_frame();
            capture_frame();
            for (int i = 0; i < 64; i++) begin
                e = exp_q.pop_front();
                n_total++;
                if ({got_v[i], got_tap[i], got_x[i], got_fe[i]} !== {1'b1, e.tap, e.x, e.fe})
                    $display("FAIL ovr_frame%0d[%0d]: got v=%b tap=%0d x=%h fe=%b, want v=1 tap=%0d x=%h fe=%b",
                             f, i, got_v[i], got_tap[i], got_x[i], got_fe[i], e.tap, e.x, e.fe);
                else n_pass++;
            end
            if (f == 0) begin
                n_total++;
                if ({got_ov[20], got_ov[21], got_ov[63]} !== 3'b011)
                    $display("FAIL ovr_onset: got ov[20]=%b ov[21]=%b ov[63]=%b, want 0 1 1",
                             got_ov[20], got_ov[21], got_ov[63]);
                else n_pass++;
                model_commit(16'h2222);
            end else begin
                n_total++;
                if (got_ov[0] !== 1'b1 || got_ov[63] !== 1'b1)
                    $display("FAIL ovr_sticky%0d: got ov[0]=%b ov[63]=%b, want 1 1", f, got_ov[0], got_ov[63]);
                else n_pass++;
            end
            if (f == 1) begin
                n_total++;
                if (got_x[0] !== 16'h2222) $display("FAIL ovr_tap0: got %h, want 2222", got_x[0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        int n;
        exp_t e;
        n = 0;
        while (!(x_valid && tap_out == 6'd30) && n < 200) begin
            step();
            n++;
        end
        n_total++;
        if (tap_out !== 6'd30) $display("FAIL mid_reach_tap30: got tap %0d, want 30", tap_out);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({x_out, tap_out, x_valid, frame_end, ready, overrun} !== 26'h0)
            $display("FAIL mid_async_reset: got x=%h tap=%0d v=%b fe=%b rdy=%b ov=%b, want all 0",
                     x_out, tap_out, x_valid, frame_end, ready, overrun);
        else n_pass++;
        step();
        step();
        reset = 1'b0;
        wait_ready(cyc);
        n_total++;
        if (cyc !== 64) $display("FAIL mid_clear_length: got %0d cycles, want 64", cyc);
        else n_pass++;
        model_clear();
        push_frame();
        clear_strobes();
        capture_frame();
        for (int i = 0; i < 64; i++) begin
            e = exp_q.pop_front();
            n_total++;
            if ({got_v[i], got_tap[i], got_x[i], got_fe[i], got_ov[i]} !== {1'b1, e.tap, e.x, e.fe, 1'b0})
                $display("FAIL mid_frame[%0d]: got v=%b tap=%0d x=%h fe=%b ov=%b, want v=1 tap=%0d x=%h fe=%b ov=0",
                         i, got_v[i], got_tap[i], got_x[i], got_fe[i], got_ov[i], e.tap, e.x, e.fe);
            else n_pass++;
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single_sample();
        test_sample_stream();
        test_coincident();
        test_overrun();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog timeout");
    end

endmodule
